// File: rtl/aes_inv_key_schedule128.sv
// rtl/aes_inv_key_schedule128.sv - AES-128 inverse key schedule, emits round keys START_ROUND down to 0
//
// Loads the round-START_ROUND key once, then streams each earlier round key
// on a valid/ready handshake until round 0 has been accepted.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   in_valid  last_key valid
//   in_ready  idle, able to accept a key
//   last_key  round-START_ROUND key {w3,w2,w1,w0}, w0 at [31:0], byte 0 of each word at [7:0]
//   rk_valid  rk_key/rk_round valid
//   rk_ready  consumer accepts the current key
//   rk_key    current round key, same packing as last_key
//   rk_round  round index of rk_key
//   rk_last   high while rk_round == 0

module aes_inv_key_schedule128 #(
    parameter int START_ROUND = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] last_key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_key,
    output logic [3:0]   rk_round,
    output logic         rk_last
);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, EMIT} state_t;

    state_t state;

    // Entry a lives at bit offset 8*(255-a); 255-a == ~a for an 8-bit index.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        sbox = SBOX_ROM[{~a, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot;
    logic [31:0]  sub;
    logic [127:0] prev_key;

    // Undo one forward expansion step: recover the previous round key.
    always_comb begin
        w0 = rk_key[31:0];
        w1 = rk_key[63:32];
        w2 = rk_key[95:64];
        w3 = rk_key[127:96];
        p3 = w3 ^ w2;
        p2 = w2 ^ w1;
        p1 = w1 ^ w0;
        rot = {p3[7:0], p3[31:8]};
        sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        p0 = w0 ^ sub ^ {24'h000000, rcon(rk_round)};
        prev_key = {p3, p2, p1, p0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            rk_valid <= 1'b0;
            rk_key   <= '0;
            rk_round <= '0;
            rk_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rk_key   <= last_key;
                        rk_round <= 4'(START_ROUND);
                        rk_last  <= 1'b0;
                        rk_valid <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (rk_round != 4'd0) begin
                            rk_key   <= prev_key;
                            rk_round <= rk_round - 4'd1;
                            rk_last  <= (rk_round == 4'd1);
                        end else begin
                            // Round 0 accepted; key and round stay on the outputs.
                            rk_valid <= 1'b0;
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
